// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: converter states, segment codes, BCD decode.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg_pkg;

    // Width of one BCD digit and the number of digits produced by the converter.
    localparam int BCD_W   = 4;
    localparam int NUM_BCD = 3;

    // Converter states. Kept as plain constants so legacy tools can consume them.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_LOAD  = 2'd2;

    // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}. The dp bit is always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // BCD nibble to segment pattern. Codes above 9 never come out of the converter,
    // but they still map to all-off so a corrupted nibble shows nothing rather than junk.
    function automatic logic [7:0] seg_decode(input logic [BCD_W-1:0] nib);
        logic [7:0] s;
        s = SEG_BLANK;
        case (nib)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: binary value and blank request in, digit select and segments out.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-sampled every cycle.
interface seg_scan_driver_if;

    logic [7:0] value;      // unsigned number to display
    logic       blank;      // force all segments off
    logic [7:0] digtal_sw;  // active-low one-hot digit select, bit 0 = rightmost digit
    logic [7:0] seg_led;    // active-low segments {dp,g,f,e,d,c,b,a}

    // Source side: the block feeding the display.
    modport master (
        output value,
        output blank,
        input  digtal_sw,
        input  seg_led
    );

    // Display driver side.
    modport slave (
        input  value,
        input  blank,
        output digtal_sw,
        output seg_led
    );

endinterface

// File: rtl/seg_scan_driver_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), free-running IDLE->SHIFT x8->LOAD.
// Latency: 10 cycles per conversion; bin sampled in IDLE, result valid on bcd while done is high.
// Backpressure: none; converts continuously, the consumer captures bcd whenever done is high.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    state_t      state_q, state_d;
    logic [7:0]  bin_q,   bin_d;
    logic [11:0] acc_q,   acc_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [11:0] adj;
    logic [19:0] shifted;

    // Add-3 correction: any digit of 5 or more would overflow past 9 once doubled.
    always_comb begin
        adj = acc_q;
        for (int n = 0; n < NUM_BCD; n++) begin
            if (acc_q[n*BCD_W +: BCD_W] >= 4'd5) begin
                adj[n*BCD_W +: BCD_W] = acc_q[n*BCD_W +: BCD_W] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    // Next-state logic: latch input, eight correct-and-shift steps, then hand the result over.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Input is only looked at here, so changes mid-conversion cannot tear the result.
                bin_d   = bin;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                acc_d = shifted[19:8];
                bin_d = shifted[7:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Converter state registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accumulator is final for the whole LOAD cycle.
    assign bcd  = acc_q;
    assign done = (state_q == ST_LOAD);

endmodule

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD display driver scanning an 8-digit common-anode 7-seg; SEG_LZB_EN enables leading-zero blanking.
// Latency: value->bcd_reg 10..19 cycles, bcd_reg/blank->seg_led 1 cycle, all outputs registered.
// Backpressure: none; scan runs freely and independently of conversion activity.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,  // cycles each digit stays lit, 2..2^20
    parameter int NUM_DIG  = 8       // physical digits scanned, 3..8
)(
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   bus
);

    localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]     DIG_LAST = 3'(NUM_DIG - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       dig_idx_q, dig_idx_d;
    logic [11:0]      bcd_reg_q, bcd_reg_d;
    logic [7:0]       digtal_sw_q, digtal_sw_d;
    logic [7:0]       seg_led_q, seg_led_d;

    logic [11:0]      conv_bcd;
    logic             conv_done;

    logic [BCD_W-1:0] hund, tens, ones;
    logic             hund_off, tens_off;
    logic [BCD_W-1:0] cur_nib;
    logic             cur_off;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (bus.value),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Scan divider and digit index, plus capture of each finished conversion.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        dig_idx_d = dig_idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            dig_idx_d = (dig_idx_q == DIG_LAST) ? 3'd0 : dig_idx_q + 3'd1;
        end
        bcd_reg_d = conv_done ? conv_bcd : bcd_reg_q;
    end

    // Leading-zero policy: the ones digit is always shown so zero still reads "0".
    always_comb begin
        hund = bcd_reg_q[11:8];
        tens = bcd_reg_q[7:4];
        ones = bcd_reg_q[3:0];
`ifdef SEG_LZB_EN
        hund_off = (hund == 4'd0);
        tens_off = hund_off && (tens == 4'd0);
`else
        hund_off = 1'b0;
        tens_off = 1'b0;
`endif
    end

    // Digit mux: physical digits above the hundreds are always dark.
    always_comb begin
        cur_nib = '0;
        cur_off = 1'b1;
        case (dig_idx_q)
            3'd0: begin
                cur_nib = ones;
                cur_off = 1'b0;
            end
            3'd1: begin
                cur_nib = tens;
                cur_off = tens_off;
            end
            3'd2: begin
                cur_nib = hund;
                cur_off = hund_off;
            end
            default: begin
                cur_nib = '0;
                cur_off = 1'b1;
            end
        endcase
        // Select and segments come from the same index and update on the same edge: no ghosting.
        digtal_sw_d = ~(8'b1 << dig_idx_q);
        seg_led_d   = (bus.blank || cur_off) ? SEG_BLANK : seg_decode(cur_nib);
    end

    // Scan and display registers; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            dig_idx_q   <= '0;
            bcd_reg_q   <= '0;
            digtal_sw_q <= 8'hFF;
            seg_led_q   <= SEG_BLANK;
        end else begin
            div_cnt_q   <= div_cnt_d;
            dig_idx_q   <= dig_idx_d;
            bcd_reg_q   <= bcd_reg_d;
            digtal_sw_q <= digtal_sw_d;
            seg_led_q   <= seg_led_d;
        end
    end

    assign bus.digtal_sw = digtal_sw_q;
    assign bus.seg_led   = seg_led_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench for seg_scan_driver with SCAN_DIV=4, NUM_DIG=8 (honours SEG_LZB_EN).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int NUM_DIG  = 8;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg_scan_driver_if sif();

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .NUM_DIG(NUM_DIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    // Pop the next expected value and compare it with what the DUT shows.
    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        vectors++;
        if (exp_q.size() == 0) e = 'x;
        else                   e = exp_q.pop_front();
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Reference segment pattern for physical digit d when displaying v.
    function automatic logic [7:0] exp_seg(input int v, input int d);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (d)
            0: return seg_tbl[o];
            1: begin
`ifdef SEG_LZB_EN
                if (h == 0 && t == 0) return 8'hFF;
`endif
                return seg_tbl[t];
            end
            2: begin
`ifdef SEG_LZB_EN
                if (h == 0) return 8'hFF;
`endif
                return seg_tbl[h];
            end
            default: return 8'hFF;
        endcase
    endfunction

    // Expected digit select k samples after the first post-reset edge.
    function automatic logic [7:0] sw_exp(input int k);
        logic [7:0] w;
        w = 8'h01 << ((k / SCAN_DIV) % NUM_DIG);
        return ~w;
    endfunction

    // Wait (bounded) for bcd_reg to take a new value; returns X on timeout.
    task automatic next_bcd(input int budget, output logic [11:0] v);
        logic [11:0] prev;
        prev = dut.bcd_reg_q;
        v = 'x;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (dut.bcd_reg_q !== prev) begin
                v = dut.bcd_reg_q;
                break;
            end
        end
    endtask

    // Wait (bounded) until digit d is selected and return its segments; X on timeout.
    task automatic seg_at(input int d, output logic [7:0] s);
        logic [7:0] w;
        w = 8'h01 << d;
        s = 'x;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (sif.digtal_sw === ~w) begin
                s = sif.seg_led;
                break;
            end
        end
    endtask

    task automatic set_value(input int v, input int budget, input string tag);
        logic [11:0] got;
        @(negedge clk);
        sif.value = 8'(v);
        exp_q.push_back({4'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
        next_bcd(budget, got);
        chk({tag, " bcd"}, {4'h0, got});
    endtask

    task automatic check_digits(input int v, input string tag);
        logic [7:0] s;
        @(posedge clk);
        for (int d = 0; d < NUM_DIG; d++) begin
            exp_q.push_back({8'h00, exp_seg(v, d)});
            seg_at(d, s);
            chk($sformatf("%s dig%0d", tag, d), {8'h00, s});
        end
    endtask

    initial begin
        logic [11:0] got;
        logic [7:0]  s;

        rst_n     = 1'b0;
        sif.value = 8'd0;
        sif.blank = 1'b0;

        // Reset held for 20 cycles: display dark throughout.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            exp_q.push_back(16'h00FF);
            chk("rst sw", {8'h00, sif.digtal_sw});
            exp_q.push_back(16'h00FF);
            chk("rst seg", {8'h00, sif.seg_led});
        end
        exp_q.push_back(16'h0000);
        chk("rst bcd", {4'h0, dut.bcd_reg_q});

        // Release and follow the scan through a full rotation and back to digit 0.
        rst_n = 1'b1;
        for (int k = 0; k < 36; k++) begin
            exp_q.push_back({8'h00, sw_exp(k)});
            @(negedge clk);
            chk($sformatf("scan k%0d", k), {8'h00, sif.digtal_sw});
            if (k == 0) begin
                exp_q.push_back(16'h00C0);
                chk("first seg", {8'h00, sif.seg_led});
            end
        end

        set_value(255, 19, "v255");
        check_digits(255, "v255");
        set_value(0, 19, "v0");
        check_digits(0, "v0");
        set_value(105, 19, "v105");
        check_digits(105, "v105");

        // 17 then 200 applied while a conversion of 17 is shifting.
        set_value(17, 19, "v17");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back({14'h0, ST_SHIFT});
        chk("toggle in shift", {14'h0, dut.u_conv.state_q});
        sif.value = 8'd200;
        exp_q.push_back(16'h0200);
        next_bcd(25, got);
        chk("toggle next bcd", {4'h0, got});
        check_digits(200, "v200");

        // Reset during the 4th shift cycle.
        sif.value = 8'd99;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dut.u_conv.state_q == ST_SHIFT && dut.u_conv.cnt_q == 3'd3) break;
        end
        exp_q.push_back(16'h0003);
        chk("shift4 found", {13'h0, dut.u_conv.cnt_q});
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(16'h00FF);
        chk("async rst sw", {8'h00, sif.digtal_sw});
        exp_q.push_back(16'h00FF);
        chk("async rst seg", {8'h00, sif.seg_led});
        exp_q.push_back(16'h0000);
        chk("async rst bcd", {4'h0, dut.bcd_reg_q});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(16'h0099);
        next_bcd(10, got);
        chk("post rst bcd", {4'h0, got});
        check_digits(99, "v99");

        // Blank: align to the start of a digit-0 slot.
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (sif.digtal_sw === 8'h7F) break;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (sif.digtal_sw === 8'hFE) break;
        end
        sif.blank = 1'b1;
        #1;
        exp_q.push_back(16'h0090);
        chk("blank lag", {8'h00, sif.seg_led});
        for (int k = 1; k < 34; k++) begin
            @(negedge clk);
            exp_q.push_back({8'h00, sw_exp(k)});
            chk($sformatf("blank sw k%0d", k), {8'h00, sif.digtal_sw});
            exp_q.push_back(16'h00FF);
            chk($sformatf("blank seg k%0d", k), {8'h00, sif.seg_led});
        end
        sif.blank = 1'b0;
        #1;
        exp_q.push_back(16'h00FF);
        chk("unblank lag", {8'h00, sif.seg_led});
        @(negedge clk);
        exp_q.push_back(16'h0090);
        chk("unblank seg", {8'h00, sif.seg_led});
        exp_q.push_back(16'h00FE);
        chk("unblank sw", {8'h00, sif.digtal_sw});

        seg_at(2, s);
        exp_q.push_back({8'h00, exp_seg(99, 2)});
        chk("final hund", {8'h00, s});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
